buffered_nic: RTL and testbench
===============================

BUFFERED_NIC -- requirements
Module: buffered_nic

Interface
REQ-001 Parameter DATA_W, default 64, meaning data and flit width in bits; SHALL be at least 8.
REQ-002 Parameter IN_DEPTH, default 4, meaning input FIFO entries; SHALL be a power of 2, at least 2.
REQ-003 Parameter OUT_DEPTH, default 4, meaning output FIFO entries; SHALL be a power of 2, at least 2.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 addr  in  2  register select: 0 = input buffer, 1 = input status, 2 = output buffer, 3 = output status.
REQ-007 d_in  in  DATA_W  processor write data.
REQ-008 nicEn  in  1  processor access enable.
REQ-009 nicWrEn  in  1  1 = write, 0 = read; qualified by nicEn.
REQ-010 net_ro  in  1  router ready to accept a flit.
REQ-011 net_polarity  in  1  router current virtual-channel polarity.
REQ-012 net_si  in  1  router flit valid.
REQ-013 net_dl  in  DATA_W  router flit data.
REQ-014 net_ri  out  1  NIC ready to accept a flit.
REQ-015 net_so  out  1  NIC flit valid.
REQ-016 net_do  out  DATA_W  NIC flit data.
REQ-017 d_out  out  DATA_W  processor read data, registered.

Function
REQ-018 Output push: a write to addr 2 SHALL push d_in when the output FIFO is not full. When the FIFO is full the write SHALL be dropped and the sticky out_ovf flag SHALL be set, even if a pop occurs in the same cycle.
REQ-019 net_so SHALL be 1 exactly when the output FIFO is non-empty; net_do SHALL present the head entry at all times.
REQ-020 Output pop: the head SHALL be popped on any edge where net_so=1, net_ro=1 and net_polarity equals net_do[DATA_W-1]. On a polarity mismatch the head SHALL be held.
REQ-021 net_ri SHALL be a registered signal, equal to 1 exactly when the input FIFO count after the current edge is below IN_DEPTH.
REQ-022 Input push: net_dl SHALL be pushed on any edge where net_ri=1 and net_si=1.
REQ-023 Input pop: a read of addr 0 with the input FIFO non-empty SHALL load d_out with the head and pop it. With the FIFO empty, the read SHALL load d_out with 0 and set the sticky in_udf flag.
REQ-024 Input status read (addr 1) SHALL load d_out as follows:
- bit DATA_W-1 = input non-empty;
- bit DATA_W-2 = in_udf;
- low bits = input count;
- all other bits 0.
The same read SHALL clear in_udf.
REQ-025 Output status read (addr 3) SHALL load d_out as follows:
- bit DATA_W-1 = output full;
- bit DATA_W-2 = out_ovf;
- low bits = output count;
- all other bits 0.
The same read SHALL clear out_ovf.
REQ-026 A read of addr 2 SHALL load d_out with 0.
REQ-027 When no read occurs, d_out SHALL hold its value.
REQ-028 A push and a pop on the same FIFO in the same edge SHALL both take effect, leaving the count unchanged.
REQ-029 Each FIFO count SHALL be $clog2(DEPTH+1) bits wide. Read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-030 Processor accesses and network transfers SHALL be independent; both may occur in the same cycle.
REQ-031 Read latency: d_out SHALL be valid on the edge following a read with nicEn=1.

Reset
REQ-032 On reset both FIFOs SHALL empty, pointers and counts SHALL go to 0, and in_udf and out_ovf SHALL clear.
REQ-033 Output values after reset: d_out=0, net_ri=1, net_so=0, net_do=0.
REQ-034 Reset asserted mid-transfer SHALL discard all buffered flits; no pop or push SHALL occur on a reset edge.

Structure
REQ-035 Shared package nic_pkg SHALL hold the four address constants and the status bit-position constants.
REQ-036 Both FIFOs SHALL be instances of a single sub-module nic_fifo, parametrised by width and depth, providing push, pop, head, count, full and empty.

Verification
REQ-037 Reset, then 4 writes of 0x8000_0000_0000_0001..4 with net_ro=0 -> net_so=1, output status = MSB 1, count 4. A fifth write -> dropped; next status read shows bit 62 = 1; the read after it shows bit 62 = 0.
REQ-038 Output FIFO holding 0x8000_..._0001, net_ro=1, net_polarity=0 for 3 cycles -> no pop. Then net_polarity=1 -> popped in 1 cycle, net_so falls.
REQ-039 net_si=1 with 5 flits 0x11..0x55 back-to-back, IN_DEPTH=4 -> net_ri falls after the 4th flit, 0x55 is not accepted, and 4 addr-0 reads return 0x11, 0x22, 0x33, 0x44 in order.
REQ-040 Input FIFO empty, addr-0 read -> d_out=0. Next addr-1 read -> bit 62 = 1, count 0.
REQ-041 Input FIFO full, addr-0 read and net_si=1 on the same edge with net_ri=1 after the pop -> count stays at 4 and FIFO order is preserved across pointer wrap.
REQ-042 Reset asserted with 2 flits queued in each FIFO -> next cycle net_so=0, net_ri=1, and both status counts read 0.

Source files
------------

// File: rtl/nic_pkg.sv
// Shared definitions for the buffered NIC: register addresses and status-word bit positions.
package nic_pkg;

  localparam logic [1:0] AddrInBuf   = 2'd0;
  localparam logic [1:0] AddrInStat  = 2'd1;
  localparam logic [1:0] AddrOutBuf  = 2'd2;
  localparam logic [1:0] AddrOutStat = 2'd3;

  // Status bit positions are counted down from the MSB; the FIFO count sits in the low bits.
  localparam int unsigned StatStateOfs = 1;
  localparam int unsigned StatFlagOfs  = 2;

endpackage

// File: rtl/nic_fifo.sv
// Synchronous FIFO with a combinational head. The head reads as zero while the FIFO is empty.
module nic_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] head_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o & ~reset;
  assign do_pop  = pop_i & ~empty_o & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage carries no reset; an empty FIFO never exposes it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/buffered_nic.sv
// Network interface: processor-side register window over an input and an output flit FIFO,
// with polarity-qualified handshake to the router.
module buffered_nic
  import nic_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned IN_DEPTH  = 4,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] d_in,
  input  logic              nicEn,
  input  logic              nicWrEn,
  input  logic              net_ro,
  input  logic              net_polarity,
  input  logic              net_si,
  input  logic [DATA_W-1:0] net_dl,
  output logic              net_ri,
  output logic              net_so,
  output logic [DATA_W-1:0] net_do,
  output logic [DATA_W-1:0] d_out
);

  localparam int unsigned InCntW  = $clog2(IN_DEPTH + 1);
  localparam int unsigned OutCntW = $clog2(OUT_DEPTH + 1);
  localparam logic [InCntW-1:0] InDepthC = InCntW'(IN_DEPTH);

  logic [DATA_W-1:0]  in_head, out_head;
  logic [InCntW-1:0]  in_count, in_count_nxt;
  logic [OutCntW-1:0] out_count;
  logic               in_full, in_empty, out_full, out_empty;
  logic               in_push, in_pop, out_push, out_pop, out_wr, rd_en;
  logic               in_udf_q, in_udf_d, out_ovf_q, out_ovf_d, net_ri_q;
  logic [DATA_W-1:0]  d_out_q, d_out_d, in_status, out_status;

  assign rd_en   = nicEn & ~nicWrEn;
  assign out_wr  = nicEn & nicWrEn & (addr == AddrOutBuf);
  assign out_push = out_wr & ~out_full;
  assign out_pop = ~out_empty & net_ro & (net_polarity == out_head[DATA_W-1]);
  assign in_push = net_ri_q & net_si & ~in_full;
  assign in_pop  = rd_en & (addr == AddrInBuf) & ~in_empty;

  assign in_count_nxt = in_count + InCntW'(in_push) - InCntW'(in_pop);

  nic_fifo #(.Width(DATA_W), .Depth(IN_DEPTH)) u_in_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (in_push),
    .pop_i   (in_pop),
    .wdata_i (net_dl),
    .head_o  (in_head),
    .count_o (in_count),
    .full_o  (in_full),
    .empty_o (in_empty)
  );

  nic_fifo #(.Width(DATA_W), .Depth(OUT_DEPTH)) u_out_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (out_push),
    .pop_i   (out_pop),
    .wdata_i (d_in),
    .head_o  (out_head),
    .count_o (out_count),
    .full_o  (out_full),
    .empty_o (out_empty)
  );

  always_comb begin
    in_status = '0;
    in_status[DATA_W-StatStateOfs] = ~in_empty;
    in_status[DATA_W-StatFlagOfs]  = in_udf_q;
    in_status[InCntW-1:0]          = in_count;
    out_status = '0;
    out_status[DATA_W-StatStateOfs] = out_full;
    out_status[DATA_W-StatFlagOfs]  = out_ovf_q;
    out_status[OutCntW-1:0]         = out_count;
  end

  always_comb begin
    d_out_d   = d_out_q;
    in_udf_d  = in_udf_q;
    out_ovf_d = out_ovf_q | (out_wr & out_full);
    if (rd_en) begin
      case (addr)
        AddrInBuf: begin
          d_out_d = in_empty ? '0 : in_head;
          if (in_empty) in_udf_d = 1'b1;
        end
        AddrInStat: begin
          d_out_d  = in_status;
          in_udf_d = 1'b0;
        end
        AddrOutBuf: d_out_d = '0;
        default: begin
          d_out_d   = out_status;
          out_ovf_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_out_q   <= '0;
      in_udf_q  <= 1'b0;
      out_ovf_q <= 1'b0;
      net_ri_q  <= 1'b1;
    end else begin
      d_out_q   <= d_out_d;
      in_udf_q  <= in_udf_d;
      out_ovf_q <= out_ovf_d;
      // Ready reflects occupancy after this edge's push and pop.
      net_ri_q  <= (in_count_nxt < InDepthC);
    end
  end

  assign d_out  = d_out_q;
  assign net_ri = net_ri_q;
  assign net_so = ~out_empty;
  assign net_do = out_head;

endmodule

// File: tb/tb_buffered_nic.sv
// Directed bench for buffered_nic: register window, FIFO boundaries, polarity handshake, reset.
module tb_buffered_nic;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in, net_dl;
  logic        nicEn, nicWrEn, net_ro, net_polarity, net_si;
  logic        net_ri, net_so;
  logic [63:0] net_do, d_out;

  int vectors = 0;
  int miscompares = 0;

  buffered_nic dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_ro       (net_ro),
    .net_polarity (net_polarity),
    .net_si       (net_si),
    .net_dl       (net_dl),
    .net_ri       (net_ri),
    .net_so       (net_so),
    .net_do       (net_do),
    .d_out        (d_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] d);
    addr = a; d_in = d; nicEn = 1'b1; nicWrEn = 1'b1;
    tick();
    nicEn = 1'b0; nicWrEn = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    addr = a; nicEn = 1'b1; nicWrEn = 1'b0;
    tick();
    nicEn = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic flit(input logic [63:0] d);
    net_si = 1'b1; net_dl = d;
    tick();
  endtask

  initial begin
    reset = 1'b1; addr = '0; d_in = '0; net_dl = '0;
    nicEn = 1'b0; nicWrEn = 1'b0; net_ro = 1'b0; net_polarity = 1'b0; net_si = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_d_out", d_out, 64'h0);
    chk("rst_net_ri", {63'h0, net_ri}, 64'h1);
    chk("rst_net_so", {63'h0, net_so}, 64'h0);
    chk("rst_net_do", net_do, 64'h0);

    // Output FIFO fill, overflow and sticky flag clear-on-read.
    wr(2'd2, 64'h8000_0000_0000_0001);
    chk("out_so_after_push", {63'h0, net_so}, 64'h1);
    chk("out_head", net_do, 64'h8000_0000_0000_0001);
    wr(2'd2, 64'h8000_0000_0000_0002);
    wr(2'd2, 64'h8000_0000_0000_0003);
    wr(2'd2, 64'h8000_0000_0000_0004);
    rd(2'd3);
    chk("out_stat_full", d_out, 64'h8000_0000_0000_0004);
    wr(2'd2, 64'h8000_0000_0000_0005);
    rd(2'd3);
    chk("out_stat_ovf", d_out, 64'hC000_0000_0000_0004);
    rd(2'd3);
    chk("out_stat_ovf_clr", d_out, 64'h8000_0000_0000_0004);
    chk("out_head_kept", net_do, 64'h8000_0000_0000_0001);
    rd(2'd2);
    chk("rd_addr2_zero", d_out, 64'h0);

    // Polarity-qualified pop.
    do_reset();
    wr(2'd2, 64'h8000_0000_0000_0001);
    net_ro = 1'b1; net_polarity = 1'b0;
    tick(); tick(); tick();
    chk("pol_mismatch_so", {63'h0, net_so}, 64'h1);
    chk("pol_mismatch_head", net_do, 64'h8000_0000_0000_0001);
    net_polarity = 1'b1;
    tick();
    chk("pol_match_so", {63'h0, net_so}, 64'h0);
    net_ro = 1'b0; net_polarity = 1'b0;
    rd(2'd3);
    chk("out_stat_empty", d_out, 64'h0);

    // Input FIFO fill to back-pressure.
    flit(64'h11); flit(64'h22); flit(64'h33);
    chk("in_ri_at3", {63'h0, net_ri}, 64'h1);
    flit(64'h44);
    chk("in_ri_at4", {63'h0, net_ri}, 64'h0);
    flit(64'h55);
    net_si = 1'b0;
    rd(2'd1);
    chk("in_stat_full", d_out, 64'h8000_0000_0000_0004);
    rd(2'd0); chk("in_pop_11", d_out, 64'h11);
    rd(2'd0); chk("in_pop_22", d_out, 64'h22);
    rd(2'd0); chk("in_pop_33", d_out, 64'h33);
    rd(2'd0); chk("in_pop_44", d_out, 64'h44);

    // Underflow.
    rd(2'd0);
    chk("in_udf_data", d_out, 64'h0);
    rd(2'd1);
    chk("in_stat_udf", d_out, 64'h4000_0000_0000_0000);
    rd(2'd1);
    chk("in_stat_udf_clr", d_out, 64'h0);

    // Full input FIFO across pointer wrap with concurrent pop and push.
    flit(64'hA1); flit(64'hA2);
    net_si = 1'b0;
    rd(2'd0); chk("wrap_pop_a1", d_out, 64'hA1);
    rd(2'd0); chk("wrap_pop_a2", d_out, 64'hA2);
    flit(64'hA3); flit(64'hA4); flit(64'hA5); flit(64'hA6);
    chk("wrap_full_ri", {63'h0, net_ri}, 64'h0);
    net_dl = 64'hA7;
    rd(2'd0);
    chk("wrap_pop_a3", d_out, 64'hA3);
    chk("wrap_ri_after_pop", {63'h0, net_ri}, 64'h1);
    tick();
    net_si = 1'b0;
    chk("wrap_ri_refull", {63'h0, net_ri}, 64'h0);
    rd(2'd1);
    chk("wrap_stat", d_out, 64'h8000_0000_0000_0004);
    rd(2'd0); chk("wrap_pop_a4", d_out, 64'hA4);
    rd(2'd0); chk("wrap_pop_a5", d_out, 64'hA5);
    rd(2'd0); chk("wrap_pop_a6", d_out, 64'hA6);
    rd(2'd0); chk("wrap_pop_a7", d_out, 64'hA7);

    // Reset with flits queued in both FIFOs.
    flit(64'hB1); flit(64'hB2);
    net_si = 1'b0;
    wr(2'd2, 64'h0000_0000_0000_00C1);
    wr(2'd2, 64'h0000_0000_0000_00C2);
    chk("pre_rst_so", {63'h0, net_so}, 64'h1);
    do_reset();
    chk("mid_rst_so", {63'h0, net_so}, 64'h0);
    chk("mid_rst_ri", {63'h0, net_ri}, 64'h1);
    chk("mid_rst_d_out", d_out, 64'h0);
    rd(2'd1);
    chk("mid_rst_in_stat", d_out, 64'h0);
    rd(2'd3);
    chk("mid_rst_out_stat", d_out, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
